// File: rtl/hwpf_stride_pkg.sv
// Shared limits, counter width and default request/response types for the
// stride-prefetch arbiter.
package hwpf_stride_pkg;

    localparam int unsigned HWPF_MAX_ENGINES  = 16;
    localparam int unsigned HWPF_MAX_INFLIGHT = 15;
    localparam int unsigned HWPF_CNT_W        = 4;

    typedef logic [HWPF_CNT_W-1:0] hwpf_cnt_t;
    typedef logic [3:0]            hwpf_tid_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        need_rsp;
        hwpf_tid_t   tid;
    } hwpf_req_t;

    typedef struct packed {
        logic [31:0] data;
        hwpf_tid_t   tid;
    } hwpf_rsp_t;

    // Index width that stays legal for a single-engine build.
    function automatic int unsigned hwpf_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hwpf_rr_select.sv
// One-hot first-requester selector: lowest index in fixed mode, first index
// at or after the pointer (wrapping) in round-robin mode.
module hwpf_rr_select
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = hwpf_idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_rr,
    output logic [N-1:0]     o_gnt
);

    logic [IDX_W-1:0] w_ptr;
    logic [2*N-1:0]   w_dbl_req;
    logic [N-1:0]     w_rot_req;
    logic [N-1:0]     w_rot_gnt;
    logic [2*N-1:0]   w_dbl_gnt;

    // Rotate so the pointer position becomes bit 0, pick the lowest set bit,
    // then rotate the one-hot result back into engine order.
    always_comb begin
        w_ptr     = i_rr ? i_ptr : '0;
        w_dbl_req = {i_req, i_req} >> w_ptr;
        w_rot_req = w_dbl_req[N-1:0];
        w_rot_gnt = w_rot_req & (-w_rot_req);
        w_dbl_gnt = {w_rot_gnt, w_rot_gnt} << w_ptr;
        o_gnt     = w_dbl_gnt[2*N-1:N];
    end

endmodule

// File: rtl/hwpf_stride_arb_credit.sv
// Arbitrates prefetch-engine requests into a single registered cache request
// port, tracking per-engine outstanding responses as issue credits.
module hwpf_stride_arb_credit
    import hwpf_stride_pkg::*;
#(
    parameter int unsigned NUM_ENGINES  = 4,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter type hpdcache_req_t       = hwpf_req_t,
    parameter type hpdcache_rsp_t       = hwpf_rsp_t,
    parameter type hpdcache_req_tid_t   = hwpf_tid_t
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    cfg_rr_i,
    input  logic          [NUM_ENGINES-1:0]         eng_req_valid_i,
    output logic          [NUM_ENGINES-1:0]         eng_req_ready_o,
    input  hpdcache_req_t [NUM_ENGINES-1:0]         eng_req_i,
    output logic          [NUM_ENGINES-1:0]         eng_rsp_valid_o,
    output hpdcache_rsp_t [NUM_ENGINES-1:0]         eng_rsp_o,
    output logic                                    hpdcache_req_valid_o,
    input  logic                                    hpdcache_req_ready_i,
    output hpdcache_req_t                           hpdcache_req_o,
    input  logic                                    hpdcache_rsp_valid_i,
    input  hpdcache_rsp_t                           hpdcache_rsp_i,
    output logic [NUM_ENGINES-1:0][HWPF_CNT_W-1:0]  inflight_o,
    output logic                                    busy_o,
    output logic                                    tid_err_o
);

    localparam int unsigned IDX_W   = hwpf_idx_w(NUM_ENGINES);
    localparam hwpf_cnt_t   MAX_CNT = HWPF_CNT_W'(MAX_INFLIGHT);

`ifndef HPDCACHE_ASSERT_OFF
    if (NUM_ENGINES < 1 || NUM_ENGINES > HWPF_MAX_ENGINES) begin : g_bad_num_engines
        $fatal(1, "hwpf_stride_arb_credit: NUM_ENGINES out of range 1..16");
    end
    if (MAX_INFLIGHT < 1 || MAX_INFLIGHT > HWPF_MAX_INFLIGHT) begin : g_bad_max_inflight
        $fatal(1, "hwpf_stride_arb_credit: MAX_INFLIGHT out of range 1..15");
    end
    if ($bits(hpdcache_req_tid_t) < $clog2(NUM_ENGINES)) begin : g_bad_tid_width
        $fatal(1, "hwpf_stride_arb_credit: transaction-id type too narrow");
    end
`endif

    logic                                   r_valid;
    hpdcache_req_t                          r_req;
    logic [IDX_W-1:0]                       r_rr;
    logic [NUM_ENGINES-1:0][HWPF_CNT_W-1:0] r_inflight;
    logic                                   r_tid_err;

    logic                   w_loadable;
    logic [NUM_ENGINES-1:0] w_eligible;
    logic [NUM_ENGINES-1:0] w_sel_req;
    logic [NUM_ENGINES-1:0] w_gnt;
    logic                   w_gnt_any;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic [IDX_W-1:0]       w_rr_next;
    hpdcache_req_t          w_load_req;
    logic [NUM_ENGINES-1:0] w_inc;
    logic                   w_rsp_in_range;
    logic                   w_tid_oob;
    logic [NUM_ENGINES-1:0] w_rsp_hit;
    logic                   w_underflow;

    // Handshakes: an engine request transfers in a cycle where its valid and
    // its ready bit are both high; the cache request transfers when
    // hpdcache_req_valid_o and hpdcache_req_ready_i are both high. Responses
    // are single-cycle strobes with no backpressure.
    assign w_loadable = !r_valid || hpdcache_req_ready_i;

    always_comb begin
        for (int i = 0; i < int'(NUM_ENGINES); i++) begin
            w_eligible[i] = eng_req_valid_i[i] &&
                            (!eng_req_i[i].need_rsp || (r_inflight[i] < MAX_CNT));
        end
        w_sel_req = w_loadable ? w_eligible : '0;
    end

    hwpf_rr_select #(
        .N     (NUM_ENGINES),
        .IDX_W (IDX_W)
    ) u_select (
        .i_req (w_sel_req),
        .i_ptr (r_rr),
        .i_rr  (cfg_rr_i),
        .o_gnt (w_gnt)
    );

    assign w_gnt_any = |w_gnt;

    always_comb begin
        w_gnt_idx  = '0;
        w_load_req = eng_req_i[0];
        for (int i = 0; i < int'(NUM_ENGINES); i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = IDX_W'(i);
                w_load_req = eng_req_i[i];
            end
        end
        w_load_req.tid = hpdcache_req_tid_t'(w_gnt_idx);
        w_rr_next = (w_gnt_idx == IDX_W'(NUM_ENGINES - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
    end

    // A response for an engine with nothing outstanding is treated as an id
    // error rather than wrapping the counter.
    always_comb begin
        w_rsp_in_range = int'(hpdcache_rsp_i.tid) < int'(NUM_ENGINES);
        w_tid_oob      = hpdcache_rsp_valid_i && !w_rsp_in_range;
        w_underflow    = 1'b0;
        for (int i = 0; i < int'(NUM_ENGINES); i++) begin
            w_inc[i]     = w_gnt[i] && eng_req_i[i].need_rsp;
            w_rsp_hit[i] = hpdcache_rsp_valid_i && w_rsp_in_range &&
                           (int'(hpdcache_rsp_i.tid) == i);
            if (w_rsp_hit[i] && !w_inc[i] && (r_inflight[i] == '0)) begin
                w_underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid    <= 1'b0;
            r_req      <= '0;
            r_rr       <= '0;
            r_inflight <= '0;
            r_tid_err  <= 1'b0;
        end else begin
            if (w_gnt_any) begin
                r_valid <= 1'b1;
                r_req   <= w_load_req;
            end else if (hpdcache_req_ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_gnt_any && cfg_rr_i) begin
                r_rr <= w_rr_next;
            end
            for (int i = 0; i < int'(NUM_ENGINES); i++) begin
                if (w_inc[i] && !w_rsp_hit[i]) begin
                    r_inflight[i] <= r_inflight[i] + hwpf_cnt_t'(1);
                end else if (!w_inc[i] && w_rsp_hit[i] && (r_inflight[i] != '0)) begin
                    r_inflight[i] <= r_inflight[i] - hwpf_cnt_t'(1);
                end
            end
            if (w_tid_oob || w_underflow) begin
                r_tid_err <= 1'b1;
            end
        end
    end

    // Combinational outputs are forced low while reset is held.
    always_comb begin
        eng_req_ready_o = rst_ni ? w_gnt : '0;
        eng_rsp_valid_o = rst_ni ? w_rsp_hit : '0;
        for (int i = 0; i < int'(NUM_ENGINES); i++) begin
            eng_rsp_o[i] = rst_ni ? hpdcache_rsp_i : '0;
        end
    end

    assign hpdcache_req_valid_o = r_valid;
    assign hpdcache_req_o       = r_req;
    assign inflight_o           = r_inflight;
    assign busy_o               = r_valid || (|r_inflight);
    assign tid_err_o            = r_tid_err;

endmodule
